// File: rtl/rggen_backdoor_ctrl_pkg.sv
// Shared types for the register backdoor access controller.
package rggen_backdoor_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RELEASE = 2'd3
  } bd_state_e;

  function automatic logic is_access(input bd_state_e s);
    return (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/rggen_backdoor_wait_counter.sv
// Saturating cycle counter measuring how long a backdoor request is held off.
module rggen_backdoor_wait_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= sat_inc(r_count);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rggen_backdoor_ctrl.sv
// Arbitrates a backdoor field access against frontdoor bus traffic and
// applies it to the field as a single strobe, then acknowledges it.
module rggen_backdoor_ctrl
  import rggen_backdoor_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int WAIT_COUNT_WIDTH = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_bd_request,
  input  logic                        i_bd_write,
  input  logic [DATA_WIDTH-1:0]       i_bd_mask,
  input  logic [DATA_WIDTH-1:0]       i_bd_data,
  output logic                        o_bd_ack,
  output logic [DATA_WIDTH-1:0]       o_bd_read_data,
  output logic [WAIT_COUNT_WIDTH-1:0] o_bd_wait_cycles,
  input  logic                        i_frontdoor_valid,
  output logic                        o_backdoor_valid,
  output logic                        o_pending_valid,
  output logic [DATA_WIDTH-1:0]       o_read_mask,
  output logic [DATA_WIDTH-1:0]       o_write_mask,
  output logic [DATA_WIDTH-1:0]       o_write_data,
  input  logic [DATA_WIDTH-1:0]       i_value
);

  bd_state_e             r_state;
  bd_state_e             w_next;
  logic                  w_capture;
  logic                  w_clear;
  logic                  w_enable;
  logic                  w_access;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A frontdoor access on the capture cycle sends the request to WAIT;
  // once in ACCESS the strobe is unconditional.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_clear   = 1'b0;
    w_enable  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_bd_request) begin
          w_capture = 1'b1;
          w_clear   = 1'b1;
          w_next    = i_frontdoor_valid ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        w_enable = 1'b1;
        if (!i_frontdoor_valid) begin
          w_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!i_bd_request) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_write <= 1'b0;
      r_mask  <= '0;
      r_data  <= '0;
    end else if (w_capture) begin
      r_write <= i_bd_write;
      r_mask  <= i_bd_mask;
      r_data  <= i_bd_data;
    end
  end

  assign w_access = is_access(r_state);

  // Read data and ack are registered off the ACCESS cycle so they appear together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_read_data <= '0;
      r_ack       <= 1'b0;
    end else begin
      r_ack <= w_access;
      if (w_access) begin
        r_read_data <= i_value & r_mask;
      end
    end
  end

  rggen_backdoor_wait_counter #(
    .WIDTH (WAIT_COUNT_WIDTH)
  ) u_wait_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_count  (o_bd_wait_cycles)
  );

  assign o_backdoor_valid = w_access;
  assign o_pending_valid  = (r_state == ST_WAIT);
  assign o_write_mask     = (w_access && r_write)  ? r_mask : '0;
  assign o_read_mask      = (w_access && !r_write) ? r_mask : '0;
  assign o_write_data     = w_access ? r_data : '0;
  assign o_bd_ack         = r_ack;
  assign o_bd_read_data   = r_read_data;

endmodule
